cache_miss_controller: RTL and testbench
========================================

// Module: cache_miss_controller
// PURPOSE
// - Sequencing FSM for the 4-way fully associative data cache. Owns per-way valid/dirty bits.
// - Classifies each CPU request as hit or miss and drives the per-way write enables wrenCache[3:0].
//   Those enables also advance the LRU ages in the LRU tracker.
// - Picks the miss victim (first invalid way, else the tracker's one-hot endLRU).
// - Sequences writeback and fill to memory with a ready handshake.
// PARAMETERS
// - CNT_W   16   width of the hit and miss performance counters (saturating)
// - WAYS    4    number of ways. Fixed at 4 because LRU ages are 2-bit; any other value is illegal.
// PORTS
// - clock      in   1      rising-edge clock
// - reset      in   1      asynchronous, active-high reset
// - reqValid   in   1      CPU request present; taken in IDLE only
// - reqWrite   in   1      1 = store, 0 = load; sampled with reqValid
// - tagMatch   in   4      raw per-way tag comparator result for the current address
// - endLRU     in   4      one-hot LRU victim from the LRU tracker
// - memReady   in   1      memory completes the current memRead/memWrite (1-cycle pulse)
// - reqReady   out  1      1 only in IDLE
// - done       out  1      1-cycle pulse when the request finishes
// - hit        out  1      valid with done: 1 = hit, 0 = miss
// - wrenCache  out  4      one-hot way write enable, 1 cycle per write
// - fillSel    out  1      data mux: 1 = memory fill data, 0 = CPU store data
// - memRead    out  1      fill request, held until memReady
// - memWrite   out  1      writeback request, held until memReady
// - memWay     out  4      one-hot way being written back or filled
// - validOut   out  4      per-way valid bits
// - dirtyOut   out  4      per-way dirty bits
// - hitCount   out  CNT_W  saturating hit counter
// - missCount  out  CNT_W  saturating miss counter
// BEHAVIOUR
// - Reset (async): state=IDLE; valid, dirty, wrenCache, memWay = 0; counters = 0.
//   memRead/memWrite/done/hit/fillSel = 0. Reset mid-transfer drops the memory request immediately.
// - States: IDLE, LOOKUP, WRITEBACK, FILL, INSTALL, MERGE, RESP. All outputs are Moore,
//   decoded from state plus registered reqWr/way.
// - IDLE: if reqValid, latch reqWrite into reqWr -> LOOKUP.
// - LOOKUP: m = tagMatch & valid.
//   - m != 0: way = lowest set bit of m (multiple matches: lowest wins). hitCount++.
//     reqWr ? MERGE : RESP.
//   - m == 0: way = lowest invalid way if any, else endLRU (non-one-hot: lowest bit;
//     zero: way0). missCount++. valid[way] & dirty[way] ? WRITEBACK : FILL.
// - WRITEBACK: memWrite=1, memWay=way. On memReady: dirty[way]=0 -> FILL.
// - FILL: memRead=1, memWay=way. On memReady -> INSTALL.
// - INSTALL: wrenCache=way, fillSel=1; valid[way]=1, dirty[way]=0. reqWr ? MERGE : RESP.
// - MERGE: wrenCache=way, fillSel=0; dirty[way]=1 -> RESP.
// - RESP: done=1; hit = registered hit flag -> IDLE.
// - Latency from acceptance edge to done:
//   - read hit: 2 cycles
//   - write hit: 3 cycles
//   - clean miss: 4 + fill wait
//   - dirty miss: 5 + both memory waits
// - memReady outside WRITEBACK/FILL is ignored. reqValid while reqReady=0 is ignored; no queueing.
// - memRead and memWrite are never both 1.
// - wrenCache is 1 for at most one cycle per INSTALL/MERGE, so the LRU ages once per cache write.
// - Counters saturate at 2^CNT_W-1; no wrap.
// STRUCTURE
// - cache_ctrl_defs.vh: state encodings (3-bit localparams), WAYS=4, one-hot way constants.
// - Sub-module cache_victim_sel (combinational):
//   - inputs: valid, tagMatch, endLRU
//   - outputs: hitWay, missWay (one-hot), anyHit
//   - implements the lowest-index priority rules above.
// - Top: FSM, way/reqWr/hit registers, valid/dirty registers, counters.
// TESTING
// - Read miss after reset (valid=0000; reqValid, reqWrite=0; memReady 3 cycles after memRead):
//   memWay=0001, INSTALL wrenCache=0001 fillSel=1, done hit=0, validOut=0001, missCount=1.
// - Read hit, way1 valid, tagMatch=0010: done 2 cycles after acceptance, hit=1,
//   wrenCache never asserted, hitCount+1.
// - Write hit, tagMatch=0100 (way2 valid): one MERGE cycle wrenCache=0100 fillSel=0,
//   dirtyOut[2]=1, done 3 cycles after acceptance.
// - Full cache, all valid, dirty=1000, endLRU=1000, write miss:
//   memWrite memWay=1000 -> memRead -> INSTALL -> MERGE; final dirtyOut=1000.
//   memWrite and memRead never overlap.
// - Reset asserted during FILL: memRead drops in the same cycle; validOut=0000, state IDLE,
//   reqReady=1 after release; a stray memReady afterwards causes no write.
// - Saturation with CNT_W=2: 5 read hits -> hitCount=3. tagMatch=0110 -> way1 chosen.
//   reqValid pulsed in LOOKUP is ignored.

Source files
------------

// File: rtl/cache_miss_controller_pkg.sv
// Shared types and helpers for the cache miss controller: FSM state encoding,
// way count and a lowest-set-bit priority helper.
package cache_miss_controller_pkg;

    localparam int unsigned NumWays = 4;

    localparam logic [NumWays-1:0] Way0 = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StFill,
        StInstall,
        StMerge,
        StResp
    } state_e;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic logic [NumWays-1:0] lowest_one(input logic [NumWays-1:0] v);
        return v & (~v + NumWays'(1));
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Combinational way selection: lowest matching valid way on a hit, otherwise the
// lowest invalid way, else the LRU tracker's victim (lowest bit, way0 if empty).
module cache_victim_sel
    import cache_miss_controller_pkg::*;
(
    input  logic [NumWays-1:0] valid_i,
    input  logic [NumWays-1:0] tag_match_i,
    input  logic [NumWays-1:0] end_lru_i,
    output logic [NumWays-1:0] hit_way_o,
    output logic [NumWays-1:0] miss_way_o,
    output logic               any_hit_o
);

    logic [NumWays-1:0] match;

    always_comb begin
        match      = tag_match_i & valid_i;
        any_hit_o  = |match;
        hit_way_o  = lowest_one(match);
        miss_way_o = Way0;
        if (!(&valid_i)) begin
            miss_way_o = lowest_one(~valid_i);
        end else if (|end_lru_i) begin
            miss_way_o = lowest_one(end_lru_i);
        end
    end

endmodule

// File: rtl/cache_miss_controller.sv
// Sequencing FSM for a 4-way fully associative cache: hit/miss classification,
// writeback/fill handshakes, per-way valid/dirty bits and saturating counters.
module cache_miss_controller
    import cache_miss_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WAYS  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqValid,
    input  logic             reqWrite,
    input  logic [WAYS-1:0]  tagMatch,
    input  logic [WAYS-1:0]  endLRU,
    input  logic             memReady,
    output logic             reqReady,
    output logic             done,
    output logic             hit,
    output logic [WAYS-1:0]  wrenCache,
    output logic             fillSel,
    output logic             memRead,
    output logic             memWrite,
    output logic [WAYS-1:0]  memWay,
    output logic [WAYS-1:0]  validOut,
    output logic [WAYS-1:0]  dirtyOut,
    output logic [CNT_W-1:0] hitCount,
    output logic [CNT_W-1:0] missCount
);

    if (WAYS != NumWays) begin : g_ways_check
        $error("cache_miss_controller supports WAYS = 4 only");
    end

    state_e             state_q, state_d;
    logic [WAYS-1:0]    way_q, way_d;
    logic [WAYS-1:0]    valid_q, valid_d;
    logic [WAYS-1:0]    dirty_q, dirty_d;
    logic               req_wr_q, req_wr_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [WAYS-1:0]    hit_way;
    logic [WAYS-1:0]    miss_way;
    logic               any_hit;

    cache_victim_sel u_victim_sel (
        .valid_i     (valid_q),
        .tag_match_i (tagMatch),
        .end_lru_i   (endLRU),
        .hit_way_o   (hit_way),
        .miss_way_o  (miss_way),
        .any_hit_o   (any_hit)
    );

    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        req_wr_d   = req_wr_q;
        hit_d      = hit_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (reqValid) begin
                    req_wr_d = reqWrite;
                    state_d  = StLookup;
                end
            end
            StLookup: begin
                hit_d = any_hit;
                if (any_hit) begin
                    way_d = hit_way;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d = req_wr_q ? StMerge : StResp;
                end else begin
                    way_d = miss_way;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d = (|(miss_way & valid_q & dirty_q)) ? StWriteback : StFill;
                end
            end
            StWriteback: begin
                if (memReady) begin
                    dirty_d = dirty_q & ~way_q;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (memReady) state_d = StInstall;
            end
            StInstall: begin
                valid_d = valid_q | way_q;
                dirty_d = dirty_q & ~way_q;
                state_d = req_wr_q ? StMerge : StResp;
            end
            StMerge: begin
                dirty_d = dirty_q | way_q;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs: a reset drops any memory request in the same cycle.
    always_comb begin
        reqReady  = (state_q == StIdle);
        done      = (state_q == StResp);
        hit       = (state_q == StResp) && hit_q;
        memWrite  = (state_q == StWriteback);
        memRead   = (state_q == StFill);
        memWay    = (memWrite || memRead) ? way_q : '0;
        fillSel   = (state_q == StInstall);
        wrenCache = ((state_q == StInstall) || (state_q == StMerge)) ? way_q : '0;
        validOut  = valid_q;
        dirtyOut  = dirty_q;
        hitCount  = hit_cnt_q;
        missCount = miss_cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            way_q      <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            req_wr_q   <= 1'b0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            req_wr_q   <= req_wr_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Randomized bench for cache_miss_controller against a per-request behavioural model
// of the cache bookkeeping, plus reset-state and reset-during-fill scenarios.
module tb_cache_miss_controller;

    localparam int unsigned CntW   = 3;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            reqValid;
    logic            reqWrite;
    logic [3:0]      tagMatch;
    logic [3:0]      endLRU;
    logic            memReady;
    logic            reqReady;
    logic            done;
    logic            hit;
    logic [3:0]      wrenCache;
    logic            fillSel;
    logic            memRead;
    logic            memWrite;
    logic [3:0]      memWay;
    logic [3:0]      validOut;
    logic [3:0]      dirtyOut;
    logic [CntW-1:0] hitCount;
    logic [CntW-1:0] missCount;

    always #5 clock = ~clock;

    cache_miss_controller #(
        .CNT_W (CntW),
        .WAYS  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqWrite  (reqWrite),
        .tagMatch  (tagMatch),
        .endLRU    (endLRU),
        .memReady  (memReady),
        .reqReady  (reqReady),
        .done      (done),
        .hit       (hit),
        .wrenCache (wrenCache),
        .fillSel   (fillSel),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memWay    (memWay),
        .validOut  (validOut),
        .dirtyOut  (dirtyOut),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [3:0]  m_valid;
    logic [3:0]  m_dirty;
    int unsigned m_hits;
    int unsigned m_misses;

    int n_wait;
    int stray_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_txn(input logic wr, input logic [3:0] tm, input logic [3:0] lru);
        int         way;
        bit         hit_e;
        bit         found;
        bit         wb_e;
        int         wbd;
        int         fd;
        int         lat_e;
        int         n;
        logic [3:0] way_oh;
        int         wb_cyc;
        int         fill_cyc;
        int         wren_cnt;
        int         bad_wren;
        int         bad_memway;
        int         overlap;
        int         order_bad;
        int         busy_ready;
        logic [1:0] sel_seq;
        logic [1:0] sel_exp;
        int         wren_exp;

        way   = 0;
        hit_e = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (tm[i] && m_valid[i]) begin
                way   = i;
                hit_e = 1'b1;
            end
        end
        if (!hit_e) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && !m_valid[i]) begin
                    way   = i;
                    found = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!found && lru[i]) begin
                    way   = i;
                    found = 1'b1;
                end
            end
        end
        way_oh = 4'(1 << way);
        wb_e   = !hit_e && m_valid[way] && m_dirty[way];
        wbd    = int'($urandom_range(3));
        fd     = int'($urandom_range(3));
        if (hit_e) lat_e = wr ? 3 : 2;
        else lat_e = 1 + (wb_e ? wbd + 1 : 0) + fd + 1 + 1 + (wr ? 1 : 0) + 1;
        if (hit_e) begin
            wren_exp = wr ? 1 : 0;
            sel_exp  = 2'b00;
        end else begin
            wren_exp = wr ? 2 : 1;
            sel_exp  = wr ? 2'b10 : 2'b01;
        end

        wb_cyc = 0; fill_cyc = 0; wren_cnt = 0; bad_wren = 0; bad_memway = 0;
        overlap = 0; order_bad = 0; busy_ready = 0; sel_seq = 2'b00;

        @(negedge clock);
        check_eq("idle_ready", 32'(reqReady), 32'd1);
        reqValid = 1'b1;
        reqWrite = wr;
        tagMatch = tm;
        endLRU   = lru;
        memReady = 1'b0;
        @(negedge clock);
        reqValid = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            if (reqReady) busy_ready++;
            if (memWrite && memRead) overlap++;
            if (memWrite || memRead) begin
                if (memWay !== way_oh) bad_memway++;
            end else if (memWay !== 4'b0000) begin
                bad_memway++;
            end
            if (|wrenCache) begin
                wren_cnt++;
                if (wrenCache !== way_oh) bad_wren++;
                sel_seq = {sel_seq[0], fillSel};
            end
            if (memWrite) begin
                if (fill_cyc != 0) order_bad++;
                wb_cyc++;
                memReady = (wb_cyc > wbd);
            end else if (memRead) begin
                fill_cyc++;
                memReady = (fill_cyc > fd);
            end else begin
                memReady = ($urandom_range(4) == 0);
            end
            // Request pulses while busy must be ignored
            reqValid = ($urandom_range(3) == 0);
            @(negedge clock);
            n++;
        end
        reqValid = 1'b0;
        memReady = 1'b0;

        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("latency", 32'(n), 32'(lat_e));
        check_eq("hit_flag", 32'(hit), 32'(hit_e));
        check_eq("wren_count", 32'(wren_cnt), 32'(wren_exp));
        check_eq("wren_way", 32'(bad_wren), 32'd0);
        check_eq("fill_sel_seq", 32'(sel_seq), 32'(sel_exp));
        check_eq("mem_way", 32'(bad_memway), 32'd0);
        check_eq("mem_overlap", 32'(overlap), 32'd0);
        check_eq("wb_before_fill", 32'(order_bad), 32'd0);
        check_eq("wb_cycles", 32'(wb_cyc), 32'(wb_e ? wbd + 1 : 0));
        check_eq("fill_cycles", 32'(fill_cyc), 32'(hit_e ? 0 : fd + 1));
        check_eq("busy_not_ready", 32'(busy_ready), 32'd0);
        check_eq("done_no_wren", 32'(wrenCache), 32'd0);

        m_valid[way] = 1'b1;
        if (!hit_e) m_dirty[way] = 1'b0;
        if (wr) m_dirty[way] = 1'b1;
        if (hit_e) m_hits = (m_hits < CntMax) ? m_hits + 1 : m_hits;
        else m_misses = (m_misses < CntMax) ? m_misses + 1 : m_misses;

        check_eq("valid_bits", 32'(validOut), 32'(m_valid));
        check_eq("dirty_bits", 32'(dirtyOut), 32'(m_dirty));
        check_eq("hit_count", 32'(hitCount), m_hits);
        check_eq("miss_count", 32'(missCount), m_misses);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(reqReady), 32'd1);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_hit"}, 32'(hit), 32'd0);
        check_eq({tag, "_wren"}, 32'(wrenCache), 32'd0);
        check_eq({tag, "_fillsel"}, 32'(fillSel), 32'd0);
        check_eq({tag, "_memrd"}, 32'(memRead), 32'd0);
        check_eq({tag, "_memwr"}, 32'(memWrite), 32'd0);
        check_eq({tag, "_memway"}, 32'(memWay), 32'd0);
        check_eq({tag, "_valid"}, 32'(validOut), 32'd0);
        check_eq({tag, "_dirty"}, 32'(dirtyOut), 32'd0);
        check_eq({tag, "_hitcnt"}, 32'(hitCount), 32'd0);
        check_eq({tag, "_misscnt"}, 32'(missCount), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        tagMatch = 4'b0000;
        endLRU   = 4'b0000;
        memReady = 1'b0;
        m_valid  = 4'b0000;
        m_dirty  = 4'b0000;
        m_hits   = 0;
        m_misses = 0;

        repeat (2) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;

        run_txn(1'b0, 4'b0000, 4'b0001);   // read miss into empty cache
        run_txn(1'b0, 4'b0001, 4'b0001);   // read hit way0
        run_txn(1'b1, 4'b0001, 4'b0010);   // write hit way0
        run_txn(1'b0, 4'b0110, 4'b1000);   // miss: way1 is lowest invalid
        run_txn(1'b0, 4'b0110, 4'b1000);   // multi-match: way1 wins
        run_txn(1'b1, 4'b0000, 4'b0001);   // write miss fills way2
        run_txn(1'b1, 4'b0000, 4'b0001);   // write miss fills way3
        run_txn(1'b1, 4'b0000, 4'b1000);   // full cache, dirty way3 victim
        run_txn(1'b0, 4'b0000, 4'b0000);   // empty LRU falls back to way0
        run_txn(1'b0, 4'b0000, 4'b0110);   // non-one-hot LRU: lowest bit

        for (int t = 0; t < 60; t++) begin
            logic [3:0] lru;
            int unsigned r;
            r = $urandom_range(7);
            if (r < 6) lru = 4'(1 << (r % 4));
            else lru = 4'($urandom_range(15));
            run_txn(1'($urandom_range(1)), 4'($urandom_range(15)), lru);
        end

        // Reset asserted while a fill is outstanding
        @(negedge clock);
        reqValid = 1'b1;
        reqWrite = 1'b0;
        tagMatch = 4'b0000;
        endLRU   = 4'b0010;
        @(negedge clock);
        reqValid = 1'b0;
        n_wait   = 0;
        while (!memRead && n_wait < 20) begin
            memReady = memWrite;
            @(negedge clock);
            n_wait++;
        end
        memReady = 1'b0;
        check_eq("fill_reached", 32'(memRead), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clock);
        reset    = 1'b0;
        m_valid  = 4'b0000;
        m_dirty  = 4'b0000;
        m_hits   = 0;
        m_misses = 0;
        stray_bad = 0;
        repeat (6) begin
            memReady = 1'($urandom_range(1));
            @(negedge clock);
            if (wrenCache !== 4'b0000 || !reqReady || memRead || memWrite) stray_bad++;
        end
        memReady = 1'b0;
        check_eq("stray_ready_ignored", 32'(stray_bad), 32'd0);
        check_eq("post_rst_valid", 32'(validOut), 32'(m_valid));

        run_txn(1'b0, 4'b1111, 4'b0100);   // cache is empty again: miss into way0

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
